// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues req/ack reads for PC strobes, buffers words with
// their PC in a small FIFO and hands them to the decoder over valid/ready.
module instr_fetch #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCAddr,
  input  logic              GetInstruction,
  input  logic              Flush,
  output logic              FetchBusy,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemReq,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] InstrOut,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic              FetchError
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W:0]    DEPTH_V   = (CNT_W + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP, ERR} state_t;

  state_t              state, state_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                mem_req_d;
  logic                fetch_error_d;
  logic                push;
  logic                pop;
  logic [CNT_W:0]      slots;

  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [ADDR_W-1:0]   pc_mem   [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0]    count, count_d;

  // An outstanding REQ already owns a FIFO slot, so a push can never overflow.
  assign slots     = {1'b0, count} + (CNT_W + 1)'(state == REQ);
  assign FetchBusy = (state != IDLE) || (slots >= DEPTH_V) || Flush;
  assign pop       = InstrValid && InstrReady && !Flush;
  assign rd_next   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      MemAddr    <= '0;
      MemReq     <= 1'b0;
      FetchError <= 1'b0;
    end else begin
      state      <= state_d;
      wait_cnt   <= wait_cnt_d;
      MemAddr    <= mem_addr_d;
      MemReq     <= mem_req_d;
      FetchError <= fetch_error_d;
    end
  end

  // Next-state and registered-output values for the request FSM.
  always_comb begin
    state_d       = state;
    wait_cnt_d    = wait_cnt;
    mem_addr_d    = MemAddr;
    mem_req_d     = MemReq;
    fetch_error_d = FetchError;
    push          = 1'b0;
    case (state)
      IDLE: begin
        if (GetInstruction && !FetchBusy) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = PCAddr;
          wait_cnt_d = '0;
        end
      end
      REQ, DROP: begin
        if (MemAck) begin
          // A flush coinciding with the ack completes the access but discards it.
          push      = (state == REQ) && !Flush;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          mem_req_d     = 1'b0;
          fetch_error_d = 1'b1;
          wait_cnt_d    = wait_cnt + WAIT_W'(1);
          state_d       = ERR;
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
          if (Flush) state_d = DROP;
        end
      end
      ERR: begin
        mem_req_d = 1'b0;
        if (Flush) begin
          fetch_error_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count;
    if (push && !pop)      count_d = count + CNT_W'(1);
    else if (!push && pop) count_d = count - CNT_W'(1);
  end

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= MemData;
      pc_mem[wr_ptr]   <= MemAddr;
    end
  end

  // Head registers load the entry that will be at the head after this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      InstrValid <= 1'b0;
      InstrOut   <= '0;
      InstrPC    <= '0;
    end else if (Flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      InstrValid <= 1'b0;
      InstrOut   <= '0;
      InstrPC    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_next;
      count      <= count_d;
      InstrValid <= (count_d != '0);
      if (push && (wr_ptr == rd_next)) begin
        InstrOut <= MemData;
        InstrPC  <= MemAddr;
      end else begin
        InstrOut <= data_mem[rd_next];
        InstrPC  <= pc_mem[rd_next];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table for fetch/back-pressure/full/flush
// flows plus hand sequences for in-flight flush, timeout and async reset.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] PCAddr;
  logic        GetInstruction;
  logic        Flush;
  logic        FetchBusy;
  logic [31:0] MemAddr;
  logic        MemReq;
  logic        MemAck;
  logic [31:0] MemData;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        FetchError;

  int total = 0;
  int bad   = 0;

  instr_fetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .PCAddr(PCAddr), .GetInstruction(GetInstruction),
    .Flush(Flush), .FetchBusy(FetchBusy), .MemAddr(MemAddr), .MemReq(MemReq),
    .MemAck(MemAck), .MemData(MemData), .InstrOut(InstrOut), .InstrPC(InstrPC),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .FetchError(FetchError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        get;
    logic [31:0] pc;
    logic        flush;
    logic        ack;
    logic [31:0] data;
    logic        ready;
    logic        busy;   // FetchBusy before the edge
    logic        req;    // outputs after the edge
    logic        valid;
    logic [31:0] out;
    logic [31:0] ipc;
  } vec_t;

  function automatic vec_t mk(input logic g, input logic [31:0] pc, input logic fl,
                              input logic ak, input logic [31:0] d, input logic rd,
                              input logic bz, input logic rq, input logic vl,
                              input logic [31:0] o, input logic [31:0] ip);
    vec_t v;
    v.get = g; v.pc = pc; v.flush = fl; v.ack = ak; v.data = d; v.ready = rd;
    v.busy = bz; v.req = rq; v.valid = vl; v.out = o; v.ipc = ip;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic [31:0] pc, input logic fl,
                       input logic ak, input logic [31:0] d, input logic rd);
    GetInstruction = g; PCAddr = pc; Flush = fl; MemAck = ak; MemData = d; InstrReady = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs [24];
  logic [31:0] exp_addr;

  initial begin
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #12;
    chk1("rst.req", MemReq, 1'b0);
    chk32("rst.addr", MemAddr, 32'h0);
    chk1("rst.valid", InstrValid, 1'b0);
    chk32("rst.out", InstrOut, 32'h0);
    chk32("rst.pc", InstrPC, 32'h0);
    chk1("rst.err", FetchError, 1'b0);
    chk1("rst.busy", FetchBusy, 1'b0);
    rst = 1'b1;
    tick();

    //             get pc           fl ak data          rd bz rq vl out           ipc
    vecs[0]  = mk(1, 32'h0000169F, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0);
    vecs[1]  = mk(0, 32'h0,        0, 0, 32'h0,        0, 1, 1, 0, 32'h0,        32'h0);
    vecs[2]  = mk(0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 1, 0, 1, 32'hDEADBEEF, 32'h169F);
    vecs[3]  = mk(0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0);
    vecs[4]  = mk(1, 32'h100,      0, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0);
    vecs[5]  = mk(0, 32'h0,        0, 1, 32'hA0000100, 0, 1, 0, 1, 32'hA0000100, 32'h100);
    vecs[6]  = mk(1, 32'h104,      0, 0, 32'h0,        0, 0, 1, 1, 32'hA0000100, 32'h100);
    vecs[7]  = mk(0, 32'h0,        0, 1, 32'hA0000104, 0, 1, 0, 1, 32'hA0000100, 32'h100);
    vecs[8]  = mk(1, 32'h108,      0, 0, 32'h0,        0, 1, 0, 1, 32'hA0000100, 32'h100);
    vecs[9]  = mk(0, 32'h0,        0, 0, 32'h0,        1, 1, 0, 1, 32'hA0000104, 32'h104);
    vecs[10] = mk(1, 32'h108,      0, 0, 32'h0,        0, 0, 1, 1, 32'hA0000104, 32'h104);
    vecs[11] = mk(0, 32'h0,        0, 1, 32'hA0000108, 1, 1, 0, 1, 32'hA0000108, 32'h108);
    vecs[12] = mk(0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0);
    vecs[13] = mk(1, 32'h200,      0, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0);
    vecs[14] = mk(0, 32'h0,        0, 1, 32'hB0000200, 0, 1, 0, 1, 32'hB0000200, 32'h200);
    vecs[15] = mk(1, 32'h204,      0, 0, 32'h0,        0, 0, 1, 1, 32'hB0000200, 32'h200);
    vecs[16] = mk(0, 32'h0,        0, 1, 32'hB0000204, 0, 1, 0, 1, 32'hB0000200, 32'h200);
    vecs[17] = mk(1, 32'h208,      0, 0, 32'h0,        1, 1, 0, 1, 32'hB0000204, 32'h204);
    vecs[18] = mk(0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 32'hB0000204, 32'h204);
    vecs[19] = mk(0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0);
    vecs[20] = mk(1, 32'h300,      0, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0);
    vecs[21] = mk(0, 32'h0,        0, 1, 32'hC0000300, 0, 1, 0, 1, 32'hC0000300, 32'h300);
    vecs[22] = mk(1, 32'h304,      1, 0, 32'h0,        0, 1, 0, 0, 32'h0,        32'h0);
    vecs[23] = mk(0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0);

    exp_addr = 32'h0;
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].get, vecs[i].pc, vecs[i].flush, vecs[i].ack, vecs[i].data, vecs[i].ready);
      #1;
      chk1($sformatf("v%0d.busy", i), FetchBusy, vecs[i].busy);
      if (vecs[i].get && !vecs[i].busy) exp_addr = vecs[i].pc;
      tick();
      chk1($sformatf("v%0d.req", i), MemReq, vecs[i].req);
      if (vecs[i].req) chk32($sformatf("v%0d.addr", i), MemAddr, exp_addr);
      chk1($sformatf("v%0d.valid", i), InstrValid, vecs[i].valid);
      if (vecs[i].valid) begin
        chk32($sformatf("v%0d.out", i), InstrOut, vecs[i].out);
        chk32($sformatf("v%0d.ipc", i), InstrPC, vecs[i].ipc);
      end
      chk1($sformatf("v%0d.err", i), FetchError, 1'b0);
    end

    // Flush while the read is in flight: the late word must be discarded.
    drive(1'b1, 32'h1ED6, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk1("fl.req0", MemReq, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    chk1("fl.busy", FetchBusy, 1'b1);
    tick();
    chk1("fl.req1", MemReq, 1'b1);
    chk1("fl.valid1", InstrValid, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk1("fl.req2", MemReq, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0);
    tick();
    chk1("fl.req3", MemReq, 1'b0);
    chk1("fl.valid3", InstrValid, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk1("fl.busy4", FetchBusy, 1'b0);
    tick();
    chk1("fl.valid4", InstrValid, 1'b0);
    drive(1'b1, 32'h21, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk32("fl.addr21", MemAddr, 32'h21);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);
    tick();
    chk1("fl.valid21", InstrValid, 1'b1);
    chk32("fl.out21", InstrOut, 32'h0BADF00D);
    chk32("fl.pc21", InstrPC, 32'h21);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk1("fl.pop21", InstrValid, 1'b0);

    // Timeout: MemReq holds for exactly MAX_WAIT cycles, then a sticky error.
    drive(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk1("to.req0", MemReq, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (14) tick();
    chk1("to.req14", MemReq, 1'b1);
    chk1("to.err14", FetchError, 1'b0);
    tick();
    chk1("to.req15", MemReq, 1'b0);
    chk1("to.err15", FetchError, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFEEDFACE, 1'b0);
    #1;
    chk1("to.busy", FetchBusy, 1'b1);
    tick();
    chk1("to.lateack.err", FetchError, 1'b1);
    chk1("to.lateack.valid", InstrValid, 1'b0);
    drive(1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk1("to.strobe.req", MemReq, 1'b0);
    chk1("to.sticky", FetchError, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk1("to.flush.err", FetchError, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk1("to.idle.busy", FetchBusy, 1'b0);
    tick();

    // Asynchronous reset in the middle of a request with a word buffered.
    drive(1'b1, 32'h4F0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hD00004F0, 1'b0);
    tick();
    drive(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk1("ar.req.pre", MemReq, 1'b1);
    chk1("ar.valid.pre", InstrValid, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk1("ar.req", MemReq, 1'b0);
    chk1("ar.valid", InstrValid, 1'b0);
    chk1("ar.err", FetchError, 1'b0);
    chk32("ar.addr", MemAddr, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    tick();
    drive(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk1("ar.post.req", MemReq, 1'b1);
    chk32("ar.post.addr", MemAddr, 32'h600);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hE0000600, 1'b0);
    tick();
    chk1("ar.post.valid", InstrValid, 1'b1);
    chk32("ar.post.out", InstrOut, 32'hE0000600);
    chk32("ar.post.pc", InstrPC, 32'h600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the PC.
- Takes the PC's PCAddr/GetInstruction strobe and issues a req/ack read to instruction memory.
- Buffers returned words with their PC in a small FIFO and presents them to the decoder over a valid/ready handshake.
- Provides back-pressure (FetchBusy) to the PC, a redirect flush, and a memory timeout error.

Parameters:
- ADDR_W, 32, width of PC/memory address
- DATA_W, 32, instruction word width
- DEPTH, 2, instruction FIFO entries (power of 2, ≥2)
- MAX_WAIT, 15, cycles REQ may wait for MemAck before error

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset (rst=0 resets)
- PCAddr  input  ADDR_W  address from PC, valid with GetInstruction
- GetInstruction  input  1  one-cycle fetch strobe from PC
- Flush  input  1  redirect (branch/jump); discards buffered/in-flight fetches
- FetchBusy  output  1  combinational; 1 = strobe this cycle will be dropped, PC must hold
- MemAddr  output  ADDR_W  memory read address
- MemReq  output  1  memory read request
- MemAck  input  1  one-cycle acknowledge, MemData valid same cycle
- MemData  input  DATA_W  memory read data
- InstrOut  output  DATA_W  FIFO head instruction
- InstrPC  output  ADDR_W  PC of FIFO head
- InstrValid  output  1  FIFO non-empty
- InstrReady  input  1  decoder accepts head
- FetchError  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): state IDLE; MemReq=0, MemAddr=0, FIFO empty, InstrValid=0, InstrOut=0, InstrPC=0, FetchError=0, wait counter=0.
- States: IDLE, REQ, DROP, ERR.
- Reservation: slots = FIFO count + (1 if request in flight). FetchBusy = (state!=IDLE) | (slots>=DEPTH) | Flush.
- IDLE:
  - GetInstruction & !FetchBusy → latch MemAddr=PCAddr, MemReq=1, go to REQ.
  - MemReq visible the cycle after the strobe.
  - A strobe while FetchBusy=1 is ignored; no state change.
- REQ:
  - MemReq and MemAddr held stable.
  - On edge with MemAck=1: push {MemAddr, MemData} to FIFO, MemReq=0, → IDLE. InstrValid rises the next cycle if the FIFO was empty.
  - Wait counter increments each cycle without ack. When it reaches MAX_WAIT: MemReq=0, FetchError=1, → ERR.
- Flush:
  - Highest priority in its cycle: FIFO cleared (InstrValid=0 next cycle), pop and push that cycle suppressed, GetInstruction ignored.
  - Flush in REQ → DROP: MemReq stays 1 until MemAck, the returned data is discarded, then → IDLE. The timeout still applies in DROP (→ ERR).
  - Flush in ERR clears FetchError → IDLE.
- ERR: MemReq=0; MemAck ignored; only Flush or reset exits.
- FIFO:
  - Pop when InstrValid & InstrReady; head advances next edge.
  - Simultaneous push and pop allowed at any count, including full.
  - Push never overflows because of reservation. Pointers wrap modulo DEPTH.
  - InstrOut/InstrPC are registered FIFO head and remain stable while InstrValid & !InstrReady.
- Reset mid-request: MemReq drops immediately (async), all buffered data lost.
- Wait counter width: clog2(MAX_WAIT+1); cleared on entry to REQ.

Test Plan:
- Basic fetch: strobe PCAddr=0x0000169F; MemAck 2 cycles later with 0xDEADBEEF → MemReq high 1 cycle after strobe; InstrValid=1, InstrOut=0xDEADBEEF, InstrPC=0x169F the cycle after ack.
- Back-pressure: InstrReady=0; fetch 0x100, then 0x104 (ack each) → FetchBusy=1 after the second fetch; a third strobe at 0x108 produces no MemReq. Raise InstrReady → 0x100 pops, FetchBusy=0, then the 0x108 fetch is accepted.
- Full push+pop: DEPTH=2 full at {0x200,0x204}; InstrReady=1 in the same cycle a third ack is blocked → verify count never exceeds 2 and order is 0x200, 0x204.
- Flush in flight: strobe 0x1ED6, assert Flush before MemAck, ack 0x12345678 3 cycles later → data never appears; InstrValid stays 0; the next strobe 0x21 returns the correct word.
- Timeout: strobe, never ack → after MAX_WAIT=15 cycles MemReq=0, FetchError=1, sticky; a late MemAck is ignored; Flush clears FetchError and returns to IDLE.
- Async reset: drop rst mid-REQ between clock edges → MemReq, InstrValid, FetchError all 0 immediately; normal fetch works after release.
